gate_vector_checker: RTL



---
 rtl/gate_vector_checker_pkg.sv | 17 +
 rtl/gate_vector_checker.sv | 135 +++++++++++++
 2 files changed

// File: rtl/gate_vector_checker_pkg.sv
// Shared definitions for gate_vector_checker: FSM state encoding and stock
// 2-input truth tables (bit k = expected output for input vector k).
package gate_vector_checker_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } gate_chk_state_e;

    localparam logic [3:0] TRUTH_AND2  = 4'b1000;
    localparam logic [3:0] TRUTH_OR2   = 4'b1110;
    localparam logic [3:0] TRUTH_XOR2  = 4'b0110;
    localparam logic [3:0] TRUTH_NAND2 = 4'b0111;

endpackage

// File: rtl/gate_vector_checker.sv
// Clocked exhaustive checker for a combinational gate: walks every input vector,
// samples the gate after SETTLE cycles and tallies mismatches against TRUTH.
// Optional macro GATE_CHK_MONITOR_EN adds simulation-only per-vector logging.
//
// state  | meaning
// IDLE   | waiting for start_i; results of the last sweep held
// DRIVE  | vector applied, settle counter running
// SAMPLE | compare dut_y_i with TRUTH, advance vector or finish
// DONE   | one-cycle done pulse, pass valid
module gate_vector_checker
    import gate_vector_checker_pkg::*;
#(
    parameter int unsigned            N_IN   = 2,
    parameter logic [(1<<N_IN)-1:0]   TRUTH  = TRUTH_AND2,
    parameter int unsigned            SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    output logic [N_IN-1:0]   vec_o,
    input  logic              dut_y_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [N_IN:0]     err_cnt_o,
    output logic [N_IN-1:0]   fail_vec_o
);

    localparam int unsigned      CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [N_IN-1:0]  VEC_ONE  = N_IN'(1);
    localparam logic [N_IN:0]    ERR_ONE  = (N_IN + 1)'(1);

    gate_chk_state_e  state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic [N_IN:0]    err_q, err_d;
    logic [N_IN-1:0]  fail_q, fail_d;
    logic             pass_q, pass_d;
    logic             mismatch;

    // Case inequality so an X/Z from the gate is reported as a failure.
    assign mismatch = (dut_y_i !== TRUTH[vec_q]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        err_d   = err_q;
        fail_d  = fail_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = DRIVE;
                    cnt_d   = '0;
                    vec_d   = '0;
                    err_d   = '0;
                    fail_d  = '0;
                    pass_d  = 1'b0;
                end
            end
            DRIVE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + ERR_ONE;
                    if (err_q == '0) begin
                        fail_d = vec_q;
                    end
                end
                if (vec_q == '1) begin
                    state_d = DONE;
                    pass_d  = (err_q == '0) && !mismatch;
                end else begin
                    state_d = DRIVE;
                    vec_d   = vec_q + VEC_ONE;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            err_q   <= '0;
            fail_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
        end
    end

    assign vec_o      = vec_q;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);
    assign pass_o     = pass_q;
    assign err_cnt_o  = err_q;
    assign fail_vec_o = fail_q;

`ifdef GATE_CHK_MONITOR_EN
    always @(posedge clk) begin
        if (rst_n && state_q == SAMPLE) begin
            $display("gate_chk: vec=%0d y=%b exp=%b %s", vec_q, dut_y_i, TRUTH[vec_q],
                     mismatch ? "FAIL" : "OK");
        end
        if (rst_n && state_q == DONE) begin
            $display("gate_chk: sweep done err_cnt=%0d %s", err_q,
                     (err_q == '0) ? "PASS" : "FAIL");
        end
    end
`else
`endif

endmodule
